// File: rtl/phase_accum.sv
// rtl/phase_accum.sv - 36-slot phase accumulator with a clear sweep after reset and a same-slot bypass
module phase_accum #(
    parameter int ACC_WIDTH       = 20,
    parameter int PHASE_OUT_WIDTH = 10,
    parameter int OPS_PER_BANK    = 18
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       op_en,
    input  logic                       bank_num,
    input  logic [4:0]                 op_num,
    input  logic [ACC_WIDTH-1:0]       phase_inc,
    input  logic                       key_on,
    output logic                       busy,
    output logic                       phase_valid,
    output logic [ACC_WIDTH-1:0]       phase_acc,
    output logic [PHASE_OUT_WIDTH-1:0] phase_out,
    output logic [5:0]                 slot_out
);
    localparam int              NUM_SLOTS = 2 * OPS_PER_BANK;
    localparam logic [5:0]      LAST_SLOT = 6'(NUM_SLOTS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state_q, state_d;
    logic [5:0]             clear_addr_q, clear_addr_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [5:0]             s1_slot_q, s1_slot_d;
    logic [ACC_WIDTH-1:0]   s1_inc_q, s1_inc_d;
    logic                   s1_key_q, s1_key_d;
    logic                   byp_q, byp_d;
    logic [ACC_WIDTH-1:0]   byp_data_q, byp_data_d;
    logic                   phase_valid_q, phase_valid_d;
    logic [ACC_WIDTH-1:0]   phase_acc_q, phase_acc_d;
    logic [5:0]             slot_out_q, slot_out_d;

    logic [ACC_WIDTH-1:0]   mem [0:NUM_SLOTS-1];
    logic [ACC_WIDTH-1:0]   rd_data_q;

    logic [5:0]             slot_in;
    logic                   req_ok;
    logic [ACC_WIDTH-1:0]   old_val;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   mem_we;
    logic [5:0]             mem_waddr;
    logic [ACC_WIDTH-1:0]   mem_wdata;

    assign slot_in = bank_num ? 6'(OPS_PER_BANK) + {1'b0, op_num} : {1'b0, op_num};
    assign req_ok  = op_en && (state_q == RUN) && (op_num < 5'(OPS_PER_BANK));
    // A read issued on the edge that writes the same slot sees stale memory; use the captured sum.
    assign old_val = byp_q ? byp_data_q : rd_data_q;
    assign sum     = s1_key_q ? '0 : old_val + s1_inc_q;

    always_comb begin
        state_d       = state_q;
        clear_addr_d  = clear_addr_q;
        s1_valid_d    = req_ok;
        s1_slot_d     = req_ok ? slot_in   : s1_slot_q;
        s1_inc_d      = req_ok ? phase_inc : s1_inc_q;
        s1_key_d      = req_ok ? key_on    : s1_key_q;
        byp_d         = req_ok && s1_valid_q && (s1_slot_q == slot_in);
        byp_data_d    = sum;
        phase_valid_d = s1_valid_q;
        phase_acc_d   = s1_valid_q ? sum       : phase_acc_q;
        slot_out_d    = s1_valid_q ? s1_slot_q : slot_out_q;
        mem_we        = 1'b0;
        mem_waddr     = s1_slot_q;
        mem_wdata     = sum;
        case (state_q)
            CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clear_addr_q;
                mem_wdata    = '0;
                clear_addr_d = clear_addr_q + 6'd1;
                if (clear_addr_q == LAST_SLOT) begin
                    state_d      = RUN;
                    clear_addr_d = '0;
                end
            end
            default: begin
                mem_we = s1_valid_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= CLEAR;
            clear_addr_q  <= '0;
            s1_valid_q    <= 1'b0;
            s1_slot_q     <= '0;
            s1_inc_q      <= '0;
            s1_key_q      <= 1'b0;
            byp_q         <= 1'b0;
            byp_data_q    <= '0;
            phase_valid_q <= 1'b0;
            phase_acc_q   <= '0;
            slot_out_q    <= '0;
        end else begin
            state_q       <= state_d;
            clear_addr_q  <= clear_addr_d;
            s1_valid_q    <= s1_valid_d;
            s1_slot_q     <= s1_slot_d;
            s1_inc_q      <= s1_inc_d;
            s1_key_q      <= s1_key_d;
            byp_q         <= byp_d;
            byp_data_q    <= byp_data_d;
            phase_valid_q <= phase_valid_d;
            phase_acc_q   <= phase_acc_d;
            slot_out_q    <= slot_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (req_ok) begin
            rd_data_q <= mem[slot_in];
        end
    end

    assign busy        = (state_q == CLEAR);
    assign phase_valid = phase_valid_q;
    assign phase_acc   = phase_acc_q;
    assign phase_out   = phase_acc_q[ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
    assign slot_out    = slot_out_q;
endmodule

// File: tb/tb_phase_accum.sv
// tb/tb_phase_accum.sv - scoreboard bench for phase_accum with directed vectors
module tb_phase_accum;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_en = 1'b0;
    logic        bank_num = 1'b0;
    logic [4:0]  op_num = '0;
    logic [19:0] phase_inc = '0;
    logic        key_on = 1'b0;
    logic        busy;
    logic        phase_valid;
    logic [19:0] phase_acc;
    logic [9:0]  phase_out;
    logic [5:0]  slot_out;

    typedef struct {
        logic [5:0]  slot;
        logic [19:0] acc;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    phase_accum dut (
        .clk(clk), .reset_n(reset_n), .op_en(op_en), .bank_num(bank_num),
        .op_num(op_num), .phase_inc(phase_inc), .key_on(key_on), .busy(busy),
        .phase_valid(phase_valid), .phase_acc(phase_acc), .phase_out(phase_out),
        .slot_out(slot_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && phase_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: got slot=%0d acc=%05h, required no result", slot_out, phase_acc);
            end else begin
                exp_t e;
                logic [9:0] eo;
                e  = exp_q.pop_front();
                eo = e.acc[19:10];
                if (phase_acc !== e.acc || phase_out !== eo || slot_out !== e.slot || cyc != e.due) begin
                    errors++;
                    $display("FAIL result: got slot=%0d acc=%05h out=%03h cyc=%0d, required slot=%0d acc=%05h out=%03h cyc=%0d",
                             slot_out, phase_acc, phase_out, cyc, e.slot, e.acc, eo, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic req(input logic b, input logic [4:0] op, input logic [19:0] inc,
                       input logic k, input logic [19:0] exp_acc, input bit push);
        exp_t e;
        op_en = 1'b1; bank_num = b; op_num = op; phase_inc = inc; key_on = k;
        if (push) begin
            e.slot = b ? 6'd18 + {1'b0, op} : {1'b0, op};
            e.acc  = exp_acc;
            e.due  = cyc + 2;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        op_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin idle(1); n++; end
        check("drain_pending", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic do_reset(input bit ops_during_clear);
        int n = 0;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", phase_valid, 0);
        check("rst_acc", phase_acc, 0);
        check("rst_out", phase_out, 0);
        check("rst_slot", slot_out, 0);
        check("rst_busy", busy, 1);
        idle(2);
        reset_n = 1'b1;
        if (ops_during_clear) begin
            op_en = 1'b1; bank_num = 1'b0; op_num = 5'd2; phase_inc = 20'h00077; key_on = 1'b0;
        end
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        op_en = 1'b0;
        check("busy_cycles", n, 36);
    endtask

    task automatic readback_all();
        for (int s = 0; s < 36; s++)
            req(s >= 18, 5'(s % 18), 20'h0, 1'b0, 20'h0, 1'b1);
        drain();
    endtask

    initial begin
        #2;
        do_reset(1'b0);
        readback_all();

        req(0, 3, 20'h00400, 0, 20'h00400, 1); idle(3);
        req(0, 3, 20'h00400, 0, 20'h00800, 1); idle(3);
        req(0, 3, 20'h00400, 0, 20'h00C00, 1); idle(3);

        req(1, 17, 20'h80000, 0, 20'h80000, 1);
        req(1, 17, 20'h80000, 0, 20'h00000, 1);
        drain();

        req(0, 5, 20'h12345, 0, 20'h12345, 1);
        req(0, 5, 20'h11111, 1, 20'h00000, 1);
        req(0, 5, 20'h00010, 0, 20'h00010, 1);
        drain();

        for (int i = 1; i <= 4; i++) req(0, 7, 20'h00001, 0, 20'(i), 1);
        drain();

        for (int i = 1; i <= 3; i++) begin
            req(0, 0, 20'h00010, 0, 20'(16 * i), 1);
            req(0, 1, 20'h00020, 0, 20'(32 * i), 1);
        end
        drain();

        req(0, 18, 20'h00abc, 0, 20'h0, 0);
        idle(3);
        req(1, 0, 20'h0, 0, 20'h0, 1);
        drain();

        req(0, 3, 20'h00005, 0, 20'h0, 0);
        do_reset(1'b1);
        readback_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phase_accum.md
# phase_accum

Per-operator phase accumulator (NCO core) for the OPL3 operator pipeline. It is the consumer side of the phase-increment stage. For each time-multiplexed operator slot it reads the stored 20-bit phase from a 36-entry memory and adds the slot's phase increment, or zeroes the phase on key-on. It writes the result back and presents the phase to the waveform/sine lookup stage. After every reset an internal clear sweep zeroes all accumulators.

## Interface
- ACC_WIDTH, 20, phase accumulator width; equals PHASE_ACC_WIDTH.
- PHASE_OUT_WIDTH, 10, width of the phase index sent to the waveform stage (accumulator MSBs).
- OPS_PER_BANK, 18, operators per bank; two banks, 36 slots total.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- op_en  in  1  slot update strobe; bank_num, op_num, phase_inc and key_on are sampled when high.
- bank_num  in  1  bank of the slot.
- op_num  in  5  operator within bank, 0..17.
- phase_inc  in  ACC_WIDTH  increment for this slot.
- key_on  in  1  phase reset request for this slot.
- busy  out  1  clear sweep in progress.
- phase_valid  out  1  one-cycle pulse; phase_acc and phase_out hold a new result.
- phase_acc  out  ACC_WIDTH  updated full accumulator value.
- phase_out  out  PHASE_OUT_WIDTH  phase_acc[ACC_WIDTH-1 -: PHASE_OUT_WIDTH].
- slot_out  out  6  slot address of the result.

## Operation
- Slot address = bank_num*OPS_PER_BANK + op_num, range 0..35.
- When op_num > 17, the request is dropped: no memory write and no phase_valid.
- Memory: 36 x ACC_WIDTH, synchronous read, single write port.
- FSM states:
  - CLEAR: entered on reset with clear_addr = 0. Each cycle writes 0 to clear_addr, then clear_addr increments. Moves to RUN after writing address 35, so CLEAR lasts exactly 36 cycles. busy = 1 and op_en is ignored.
  - RUN: busy = 0; normal updates.
- Update rule:
  - new = key_on ? 0 : (old + phase_inc) mod 2^ACC_WIDTH.
  - Carry out is discarded; wrap-around is the intended behaviour.
- Bypass:
  - When a request targets the slot whose result is being written on the same edge, "old" is taken from the in-flight sum, not the memory.
  - The design does not rely on the memory's read-during-write behaviour.
  - Back-to-back updates to one slot therefore accumulate correctly.
- Different slots on consecutive cycles are fully pipelined, one update per cycle.

## Timing
- Pipeline:
  - Edge E0: op_en high is sampled and the read is issued.
  - Edge E1: the sum is registered into the outputs and written back to memory.
  - Outputs are valid for one cycle after E1 (latency 2 edges from the op_en sampling edge to output).
- phase_valid is high exactly one cycle per accepted request. phase_acc, phase_out and slot_out hold their values until the next valid result.
- Reset values, asynchronous: phase_valid = 0, phase_acc = 0, phase_out = 0, slot_out = 0, busy = 1, state = CLEAR, pipeline valid bits = 0.
- Reset mid-operation: in-flight requests are discarded and no write completes. The clear sweep restarts at address 0 after reset_n deasserts.
- busy falls on the edge that completes the address-35 write. The first op_en accepted is the one sampled on the following edge.
- An op_en high during CLEAR is lost and never produces phase_valid.

## Test plan
- Reset release -> busy = 1 for exactly 36 cycles, then 0. Reading any slot with phase_inc = 0 then returns phase_acc = 0.
- Slot bank 0/op 3, phase_inc = 0x00400, three updates spaced 4 cycles apart -> phase_acc = 0x00400, 0x00800, 0x00C00. phase_out = 0x001, 0x002, 0x003. slot_out = 3.
- Bank 1/op 17, phase_inc = 0x80000, two updates -> 0x80000, then 0x00000 (wrap). slot_out = 35.
- Slot 5 accumulated to 0x12345, then an update with key_on = 1 and phase_inc = 0x11111 -> phase_acc = 0. The next update with phase_inc = 0x00010 gives 0x00010.
- Same slot on 4 consecutive cycles with phase_inc = 0x00001 -> results 1, 2, 3, 4 on consecutive cycles. Alternating slots 0/1 with increments 0x10/0x20 -> each slot accumulates independently.
- op_num = 18 with op_en -> no phase_valid and no memory change. reset_n pulsed low mid-stream -> outputs 0 immediately, busy = 1 for 36 cycles, all slots read back 0.
